// File: rtl/nonpu_activity_pkg.sv
// -----------------------------------------------------------------------------
// nonpu_activity_pkg
// Shared definitions for the spike-driven activity stages.
//   ACT_WIDTH  : width of the activity word consumed by the level monitor
//   POP_MAX_W  : widest spike vector the popcount helper accepts
//   popcount() : number of set bits among the low 'w' bits of a vector
//   sat_add()  : saturating add onto an ACT_WIDTH value, returns {clip, sum}
// -----------------------------------------------------------------------------
package nonpu_activity_pkg;

   localparam int ACT_WIDTH = 16;
   localparam int POP_MAX_W = 32;
   localparam logic [ACT_WIDTH-1:0] ACT_MAX = {ACT_WIDTH{1'b1}};

   // Callers zero-extend their spike vector to POP_MAX_W and pass the real width.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v,
                                            input int unsigned w);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         if (i < int'(w) && v[i]) begin
            cnt = cnt + 1;
         end
      end
      return cnt;
   endfunction

   // Bit ACT_WIDTH of the result flags that the sum was clipped.
   function automatic logic [ACT_WIDTH:0] sat_add(input logic [ACT_WIDTH-1:0] base,
                                                  input logic [31:0] addend);
      logic [32:0] sum;
      sum = {{(33-ACT_WIDTH){1'b0}}, base} + {1'b0, addend};
      if (sum > {{(33-ACT_WIDTH){1'b0}}, ACT_MAX}) begin
         return {1'b1, ACT_MAX};
      end
      return {1'b0, sum[ACT_WIDTH-1:0]};
   endfunction

endpackage

// File: rtl/activity_integrator_if.sv
// -----------------------------------------------------------------------------
// activity_integrator_if
// Control, spike bus and result signals of the activity integrator.
//   master : drives enable/clear/spike_valid/spike_in, observes the results
//   slave  : the integrator itself, produces activity/activity_valid/saturated
// -----------------------------------------------------------------------------
interface activity_integrator_if #(
   parameter int SPIKE_W = 4,
   parameter int WIDTH   = 16
);
   logic               enable;
   logic               clear;
   logic               spike_valid;
   logic [SPIKE_W-1:0] spike_in;
   logic [WIDTH-1:0]   activity;
   logic               activity_valid;
   logic               saturated;

   modport master (
      output enable, clear, spike_valid, spike_in,
      input  activity, activity_valid, saturated
   );

   modport slave (
      input  enable, clear, spike_valid, spike_in,
      output activity, activity_valid, saturated
   );
endinterface

// File: rtl/activity_integrator_spike_weight.sv
// -----------------------------------------------------------------------------
// spike_weight
// Combinational spike weighting: inc = popcount(spike_in) * INC.
//   spike_in : one bit per spike line
//   inc      : weighted increment, OUT_W bits wide, never truncated for the
//              default SPIKE_W/INC/WIDTH combination
// -----------------------------------------------------------------------------
module spike_weight
   import nonpu_activity_pkg::*;
#(
   parameter int SPIKE_W = 4,
   parameter int INC     = 64,
   parameter int OUT_W   = 20
) (
   input  logic [SPIKE_W-1:0] spike_in,
   output logic [OUT_W-1:0]   inc
);

   int unsigned pop_count;

   always_comb begin
      pop_count = popcount(POP_MAX_W'(spike_in), SPIKE_W);
      inc       = OUT_W'(pop_count * INC);
   end

endmodule

// File: rtl/activity_integrator.sv
// -----------------------------------------------------------------------------
// activity_integrator
// Leaky spike-rate integrator. Weighted spikes accumulate every enabled
// cycle; once per DECAY_PERIOD enabled cycles the value loses
// (activity >> DECAY_SHIFT) before that cycle's increment is added, and a
// one-cycle strobe marks the decayed value for the downstream monitor.
//   clk                 : rising-edge clock
//   reset               : synchronous, active-high
//   bus.enable          : run when high, freeze value and window when low
//   bus.clear           : synchronous soft clear
//   bus.spike_valid     : qualifies bus.spike_in
//   bus.spike_in        : one bit per spike line
//   bus.activity        : registered, saturating accumulator
//   bus.activity_valid  : pulse in the cycle after a decay tick
//   bus.saturated       : sticky clip flag, cleared by reset or clear
// WIDTH must equal ACT_WIDTH from the shared package.
// -----------------------------------------------------------------------------
module activity_integrator
   import nonpu_activity_pkg::*;
#(
   parameter int SPIKE_W      = 4,
   parameter int WIDTH        = 16,
   parameter int INC          = 64,
   parameter int DECAY_PERIOD = 256,
   parameter int DECAY_SHIFT  = 3
) (
   input logic                  clk,
   input logic                  reset,
   activity_integrator_if.slave bus
);

   localparam int INC_W = WIDTH + SPIKE_W;
   localparam int CNT_W = $clog2(DECAY_PERIOD);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECAY_PERIOD - 1);

   logic [WIDTH-1:0] activity_reg;
   logic [WIDTH-1:0] activity_next;
   logic [CNT_W-1:0] win_cnt_reg;
   logic             valid_reg;
   logic             sat_reg;

   logic [INC_W-1:0] raw_inc;
   logic [INC_W-1:0] inc;
   logic             tick;
   logic [WIDTH-1:0] decayed;
   logic             clip;

   spike_weight #(
      .SPIKE_W (SPIKE_W),
      .INC     (INC),
      .OUT_W   (INC_W)
   ) u_spike_weight (
      .spike_in (bus.spike_in),
      .inc      (raw_inc)
   );

   always_comb begin
      inc  = (bus.spike_valid && bus.enable) ? raw_inc : '0;
      tick = bus.enable && (win_cnt_reg == LAST_CNT);
      // Shift-subtract never underflows: the subtrahend is at most activity.
      decayed = tick ? (activity_reg - (activity_reg >> DECAY_SHIFT)) : activity_reg;
      {clip, activity_next} = sat_add(decayed, 32'(inc));
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         activity_reg <= '0;
         win_cnt_reg  <= '0;
         valid_reg    <= 1'b0;
         sat_reg      <= 1'b0;
      end else begin
         // tick already requires enable, so the strobe drops while idle.
         valid_reg <= tick;
         if (bus.enable) begin
            activity_reg <= activity_next;
            sat_reg      <= sat_reg | clip;
            win_cnt_reg  <= tick ? '0 : win_cnt_reg + 1'b1;
         end
      end
   end

   assign bus.activity       = activity_reg;
   assign bus.activity_valid = valid_reg;
   assign bus.saturated      = sat_reg;

endmodule
